// File: rtl/cpu_pkg.sv
// Shared types and codes for the decode/issue hazard and bypass logic.
package cpu_pkg;

    localparam int unsigned ENT_REG_W = 8;
    localparam int unsigned ENT_REM_W = 8;
    localparam int unsigned PERF_W    = 3;

    typedef enum logic [1:0] {
        CLASS_NONE  = 2'd0,
        CLASS_FIXED = 2'd1,
        CLASS_VAR   = 2'd2,
        CLASS_RSVD  = 2'd3
    } issue_class_e;

    localparam logic [PERF_W-1:0] PERF_OK         = 3'd0;
    localparam logic [PERF_W-1:0] PERF_JUMP       = 3'd1;
    localparam logic [PERF_W-1:0] PERF_SCOREBOARD = 3'd2;
    localparam logic [PERF_W-1:0] PERF_RESOURCE   = 3'd3;

    localparam int unsigned RES_MEM = 0;
    localparam int unsigned RES_DIV = 1;

    // Fields are sized for the largest supported register file and pipe depth.
    typedef struct packed {
        logic                 valid;
        logic [ENT_REG_W-1:0] dest;
        logic [ENT_REM_W-1:0] remain;
    } pipe_entry_t;

endpackage

// File: rtl/cpu_bypass_match.sv
// Youngest-match search of the shadow pipe for one source operand.
module cpu_bypass_match
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DEPTH    = 2,
    localparam int unsigned REG_W   = $clog2(NUM_REGS),
    localparam int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                    src_use,
    input  logic [REG_W-1:0]        src_reg,
    input  pipe_entry_t [DEPTH-1:0] pipe,
    output logic [SEL_W-1:0]        sel_c,
    output logic                    hazard_c
);

    // Scan oldest to youngest so the lowest matching stage wins.
    always_comb begin
        sel_c    = '0;
        hazard_c = 1'b0;
        if (src_use && (src_reg != '0)) begin
            for (int s = int'(DEPTH); s >= 1; s--) begin
                if (pipe[s-1].valid && (pipe[s-1].dest == ENT_REG_W'(src_reg))) begin
                    sel_c    = (pipe[s-1].remain == '0) ? SEL_W'(s) : '0;
                    hazard_c = (pipe[s-1].remain != '0);
                end
            end
        end
    end

endmodule

// File: rtl/cpu_hazard_unit.sv
// Issue-stage hazard detection, bypass selection, variable-latency scoreboard
// and registered stall classification.
module cpu_hazard_unit
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned NUM_WB   = 2,
    parameter int unsigned NUM_RES  = 2,
    localparam int unsigned REG_W   = $clog2(NUM_REGS),
    localparam int unsigned SEL_W   = $clog2(DEPTH + 1),
    localparam int unsigned LAT_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       issue_valid,
    input  logic [NUM_SRC-1:0]         issue_use,
    input  logic [NUM_SRC*REG_W-1:0]   issue_src,
    input  logic [REG_W-1:0]           issue_dest,
    input  logic [1:0]                 issue_class,
    input  logic [LAT_W-1:0]           issue_lat,
    input  logic [NUM_RES-1:0]         issue_res,
    input  logic [NUM_RES-1:0]         res_busy,
    input  logic                       flush,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*REG_W-1:0]    wb_dest,
    output logic                       issue_ready,
    output logic                       issue_fire,
    output logic [NUM_SRC*SEL_W-1:0]   bypass_sel,
    output logic [NUM_REGS-1:0]        busy_mask,
    output logic [PERF_W-1:0]          perf_count
);

    pipe_entry_t [DEPTH-1:0] pipe_q, pipe_d;
    logic [NUM_REGS-1:0]     busy_q, busy_d;
    logic [REG_W-1:0]        latent_q, latent_d;
    logic                    flush_q;
    logic [PERF_W-1:0]       perf_q, perf_d;

    logic [NUM_REGS-1:0] wb_clr_c;
    logic [NUM_REGS-1:0] busy_eff_c;
    logic [NUM_SRC-1:0]  fix_haz_c;
    logic [NUM_SRC-1:0]  sb_haz_c;
    logic                is_fixed_c, is_var_c;
    logic                data_haz_c, res_haz_c;

    assign is_fixed_c = (issue_class == 2'(CLASS_FIXED));
    assign is_var_c   = (issue_class == 2'(CLASS_VAR));

    // Retiring results are visible to readers in the same cycle.
    always_comb begin
        wb_clr_c = '0;
        for (int w = 0; w < int'(NUM_WB); w++) begin
            if (wb_valid[w]) begin
                wb_clr_c[wb_dest[w*REG_W +: REG_W]] = 1'b1;
            end
        end
    end

    assign busy_eff_c = busy_q & ~wb_clr_c;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        cpu_bypass_match #(
            .NUM_REGS (NUM_REGS),
            .DEPTH    (DEPTH)
        ) u_match (
            .src_use  (issue_use[k]),
            .src_reg  (issue_src[k*REG_W +: REG_W]),
            .pipe     (pipe_q),
            .sel_c    (bypass_sel[k*SEL_W +: SEL_W]),
            .hazard_c (fix_haz_c[k])
        );
        assign sb_haz_c[k] = issue_use[k] & busy_eff_c[issue_src[k*REG_W +: REG_W]];
    end

    assign data_haz_c  = (|fix_haz_c) | (|sb_haz_c)
                       | ((is_fixed_c | is_var_c) & busy_eff_c[issue_dest]);
    assign res_haz_c   = |(issue_res & res_busy);
    assign issue_ready = !issue_valid || !(data_haz_c || res_haz_c);
    assign issue_fire  = issue_valid & issue_ready & ~flush;

    // Next-state for shadow pipe, scoreboard and perf classification.
    always_comb begin
        pipe_d   = '0;
        busy_d   = busy_eff_c;
        latent_d = '0;
        perf_d   = PERF_OK;

        if (issue_fire && is_fixed_c) begin
            pipe_d[0].valid  = 1'b1;
            pipe_d[0].dest   = ENT_REG_W'(issue_dest);
            pipe_d[0].remain = (issue_lat == '0) ? '0 : ENT_REM_W'(issue_lat - 1'b1);
        end
        for (int s = 1; s < int'(DEPTH); s++) begin
            pipe_d[s] = pipe_q[s-1];
            if (pipe_q[s-1].remain != '0) begin
                pipe_d[s].remain = pipe_q[s-1].remain - 1'b1;
            end
            if ((s == 1) && flush) begin
                pipe_d[s].valid = 1'b0;
            end
        end

        if (issue_fire && is_var_c) begin
            busy_d[issue_dest] = 1'b1;
            latent_d           = issue_dest;
        end
        // A flush cancels the load issued last cycle, overriding set and retire.
        if (flush) begin
            busy_d[latent_q] = 1'b0;
        end
        busy_d[0] = 1'b0;

        if (flush || flush_q) begin
            perf_d = PERF_JUMP;
        end else if (issue_valid && data_haz_c) begin
            perf_d = PERF_SCOREBOARD;
        end else if (issue_valid && res_haz_c) begin
            perf_d = PERF_RESOURCE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q   <= '0;
            busy_q   <= '0;
            latent_q <= '0;
            flush_q  <= 1'b0;
            perf_q   <= PERF_OK;
        end else begin
            pipe_q   <= pipe_d;
            busy_q   <= busy_d;
            latent_q <= latent_d;
            flush_q  <= flush;
            perf_q   <= perf_d;
        end
    end

    assign busy_mask  = busy_q;
    assign perf_count = perf_q;

endmodule

// File: tb/tb_cpu_hazard_unit.sv
// Scenario bench for cpu_hazard_unit: expectations are queued with the cycle
// in which the DUT should show them and compared when that cycle is sampled.
module tb_cpu_hazard_unit;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        issue_valid;
    logic [1:0]  issue_use;
    logic [9:0]  issue_src;
    logic [4:0]  issue_dest;
    logic [1:0]  issue_class;
    logic [1:0]  issue_lat;
    logic [1:0]  issue_res;
    logic [1:0]  res_busy;
    logic        flush;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_dest;
    logic        issue_ready;
    logic        issue_fire;
    logic [3:0]  bypass_sel;
    logic [31:0] busy_mask;
    logic [2:0]  perf_count;

    cpu_hazard_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_use   (issue_use),
        .issue_src   (issue_src),
        .issue_dest  (issue_dest),
        .issue_class (issue_class),
        .issue_lat   (issue_lat),
        .issue_res   (issue_res),
        .res_busy    (res_busy),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_dest     (wb_dest),
        .issue_ready (issue_ready),
        .issue_fire  (issue_fire),
        .bypass_sel  (bypass_sel),
        .busy_mask   (busy_mask),
        .perf_count  (perf_count)
    );

    always #5 clock = ~clock;

    typedef enum int {K_READY, K_FIRE, K_SEL0, K_SEL1, K_BUSY, K_PERF} kind_e;
    typedef struct {
        string       tag;
        kind_e       kind;
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] observe(kind_e k);
        case (k)
            K_READY: return 32'(issue_ready);
            K_FIRE:  return 32'(issue_fire);
            K_SEL0:  return 32'(bypass_sel[1:0]);
            K_SEL1:  return 32'(bypass_sel[3:2]);
            K_BUSY:  return busy_mask;
            default: return 32'(perf_count);
        endcase
    endfunction

    task automatic expect_at(input string tag, input kind_e k, input int due, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = k; e.due = due; e.val = v;
        sbq.push_back(e);
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_use = '0; issue_src = '0; issue_dest = '0;
        issue_class = '0; issue_lat = '0; issue_res = '0; res_busy = '0;
        flush = 1'b0; wb_valid = '0; wb_dest = '0;
    endtask

    task automatic op(input logic [1:0] cls, input logic [4:0] dest, input logic [1:0] lat);
        issue_valid = 1'b1; issue_class = cls; issue_dest = dest; issue_lat = lat;
    endtask

    task automatic rd(input int k, input logic [4:0] r);
        issue_valid = 1'b1; issue_use[k] = 1'b1; issue_src[k*5 +: 5] = r;
    endtask

    task automatic wb(input int p, input logic [4:0] r);
        wb_valid[p] = 1'b1; wb_dest[p*5 +: 5] = r;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        for (int c = 0; c < 2; c++) begin
            idle_inputs();
            case (c)
                0: begin
                    expect_at("rst_ready", K_READY, c, 1);
                    expect_at("rst_sel0", K_SEL0, c, 0);
                    expect_at("rst_busy", K_BUSY, c, 0);
                    expect_at("rst_perf", K_PERF, c, 32'(PERF_OK));
                end
                1: begin
                    rd(0, 5'd3); rd(1, 5'd5);
                    expect_at("rst_rd_ready", K_READY, c, 1);
                    expect_at("rst_rd_fire", K_FIRE, c, 1);
                    expect_at("rst_rd_sel1", K_SEL1, c, 0);
                end
                default: ;
            endcase
            @(negedge clock);
            for (int i = 0; i < sbq.size(); ) begin
                if (sbq[i].due <= c) begin
                    got = observe(sbq[i].kind); n_tests++;
                    if (got !== sbq[i].val) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h", sbq[i].tag, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end else i++;
            end
            if (c == 0) reset_n = 1'b1;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_fixed_bypass();
        logic [31:0] got;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            case (c)
                0: begin op(2'd1, 5'd3, 2'd1); expect_at("fx_fire", K_FIRE, c, 1); end
                1: begin
                    rd(0, 5'd3);
                    expect_at("fx_c1_ready", K_READY, c, 1);
                    expect_at("fx_c1_sel", K_SEL0, c, 1);
                end
                2: begin
                    rd(0, 5'd3); rd(1, 5'd3);
                    expect_at("fx_c2_sel0", K_SEL0, c, 2);
                    expect_at("fx_c2_sel1", K_SEL1, c, 2);
                end
                3: begin
                    rd(0, 5'd3);
                    expect_at("fx_c3_sel", K_SEL0, c, 0);
                    expect_at("fx_c3_ready", K_READY, c, 1);
                end
                default: ;
            endcase
            @(negedge clock);
            for (int i = 0; i < sbq.size(); ) begin
                if (sbq[i].due <= c) begin
                    got = observe(sbq[i].kind); n_tests++;
                    if (got !== sbq[i].val) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h", sbq[i].tag, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end else i++;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_fixed_stall();
        logic [31:0] got;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            case (c)
                0: begin op(2'd1, 5'd5, 2'd2); expect_at("mul_fire", K_FIRE, c, 1); end
                1: begin
                    rd(0, 5'd5);
                    expect_at("mul_c1_ready", K_READY, c, 0);
                    expect_at("mul_c1_fire", K_FIRE, c, 0);
                    expect_at("mul_perf_sb", K_PERF, c + 1, 32'(PERF_SCOREBOARD));
                end
                2: begin
                    rd(0, 5'd5);
                    expect_at("mul_c2_ready", K_READY, c, 1);
                    expect_at("mul_c2_sel", K_SEL0, c, 2);
                    expect_at("mul_perf_ok", K_PERF, c + 1, 32'(PERF_OK));
                end
                default: ;
            endcase
            @(negedge clock);
            for (int i = 0; i < sbq.size(); ) begin
                if (sbq[i].due <= c) begin
                    got = observe(sbq[i].kind); n_tests++;
                    if (got !== sbq[i].val) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h", sbq[i].tag, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end else i++;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_load();
        logic [31:0] got;
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            case (c)
                0: begin
                    op(2'd2, 5'd7, 2'd0);
                    expect_at("ld_fire", K_FIRE, c, 1);
                    expect_at("ld_busy_set", K_BUSY, c + 1, 32'h80);
                end
                1: begin
                    rd(0, 5'd7);
                    expect_at("ld_c1_ready", K_READY, c, 0);
                    expect_at("ld_perf_sb", K_PERF, c + 1, 32'(PERF_SCOREBOARD));
                end
                2: begin rd(0, 5'd7); expect_at("ld_c2_ready", K_READY, c, 0); end
                3: begin
                    rd(0, 5'd7); wb(0, 5'd7);
                    expect_at("ld_wb_ready", K_READY, c, 1);
                    expect_at("ld_wb_fire", K_FIRE, c, 1);
                    expect_at("ld_busy_clr", K_BUSY, c + 1, 0);
                end
                5: begin
                    op(2'd2, 5'd8, 2'd0); wb(0, 5'd8);
                    expect_at("set_wins_fire", K_FIRE, c, 1);
                    expect_at("set_wins_busy", K_BUSY, c + 1, 32'h100);
                end
                6: begin
                    op(2'd1, 5'd8, 2'd1);
                    expect_at("waw_ready", K_READY, c, 0);
                    expect_at("waw_perf", K_PERF, c + 1, 32'(PERF_SCOREBOARD));
                end
                7: begin wb(1, 5'd8); expect_at("ld8_clr", K_BUSY, c + 1, 0); end
                default: ;
            endcase
            @(negedge clock);
            for (int i = 0; i < sbq.size(); ) begin
                if (sbq[i].due <= c) begin
                    got = observe(sbq[i].kind); n_tests++;
                    if (got !== sbq[i].val) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h", sbq[i].tag, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end else i++;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_flush();
        logic [31:0] got;
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            case (c)
                0: begin
                    op(2'd2, 5'd9, 2'd0);
                    expect_at("fl_ld_busy", K_BUSY, c + 1, 32'h200);
                end
                1: begin
                    flush = 1'b1; op(2'd2, 5'd10, 2'd0);
                    expect_at("fl_fire", K_FIRE, c, 0);
                    expect_at("fl_busy_clr", K_BUSY, c + 1, 0);
                    expect_at("fl_perf1", K_PERF, c + 1, 32'(PERF_JUMP));
                end
                2: expect_at("fl_perf2", K_PERF, c + 1, 32'(PERF_JUMP));
                3: expect_at("fl_perf_ok", K_PERF, c + 1, 32'(PERF_OK));
                4: op(2'd1, 5'd11, 2'd1);
                5: begin
                    flush = 1'b1; rd(0, 5'd11);
                    expect_at("fl_s1_sel", K_SEL0, c, 1);
                    expect_at("fl_s1_fire", K_FIRE, c, 0);
                    expect_at("fl_s1_perf1", K_PERF, c + 1, 32'(PERF_JUMP));
                end
                6: begin
                    rd(0, 5'd11);
                    expect_at("fl_s1_dropped", K_SEL0, c, 0);
                    expect_at("fl_s1_perf2", K_PERF, c + 1, 32'(PERF_JUMP));
                end
                7: expect_at("fl_s1_perf_ok", K_PERF, c + 1, 32'(PERF_OK));
                default: ;
            endcase
            @(negedge clock);
            for (int i = 0; i < sbq.size(); ) begin
                if (sbq[i].due <= c) begin
                    got = observe(sbq[i].kind); n_tests++;
                    if (got !== sbq[i].val) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h", sbq[i].tag, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end else i++;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_resource();
        logic [31:0] got;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            case (c)
                0: begin
                    op(2'd0, 5'd0, 2'd0); issue_res = 2'b01; res_busy = 2'b01;
                    expect_at("res_ready", K_READY, c, 0);
                    expect_at("res_fire", K_FIRE, c, 0);
                    expect_at("res_perf", K_PERF, c + 1, 32'(PERF_RESOURCE));
                end
                1: begin
                    op(2'd0, 5'd0, 2'd0); issue_res = 2'b01;
                    expect_at("res_rel_fire", K_FIRE, c, 1);
                    expect_at("res_rel_perf", K_PERF, c + 1, 32'(PERF_OK));
                end
                2: begin
                    op(2'd0, 5'd0, 2'd0); issue_res = 2'b10; res_busy = 2'b01;
                    expect_at("res_other_ready", K_READY, c, 1);
                end
                3: begin
                    op(2'd0, 5'd0, 2'd0); issue_res = 2'b10; res_busy = 2'b10;
                    expect_at("res_div_ready", K_READY, c, 0);
                end
                default: ;
            endcase
            @(negedge clock);
            for (int i = 0; i < sbq.size(); ) begin
                if (sbq[i].due <= c) begin
                    got = observe(sbq[i].kind); n_tests++;
                    if (got !== sbq[i].val) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h", sbq[i].tag, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end else i++;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            case (c)
                0: op(2'd2, 5'd4, 2'd0);
                1: begin
                    op(2'd2, 5'd6, 2'd0);
                    expect_at("b2b_fire", K_FIRE, c, 1);
                    expect_at("b2b_busy2", K_BUSY, c + 1, 32'h50);
                end
                2: begin op(2'd1, 5'd0, 2'd1); expect_at("r0_dest_fire", K_FIRE, c, 1); end
                3: begin
                    rd(0, 5'd0); rd(1, 5'd4); wb(0, 5'd4); wb(1, 5'd6);
                    expect_at("r0_ready", K_READY, c, 1);
                    expect_at("r0_sel0", K_SEL0, c, 0);
                    expect_at("r4_sel1", K_SEL1, c, 0);
                    expect_at("dual_wb_busy", K_BUSY, c + 1, 0);
                end
                4: begin
                    op(2'd2, 5'd12, 2'd0);
                    expect_at("ld12_busy", K_BUSY, c + 1, 32'h1000);
                end
                6: begin
                    reset_n = 1'b0; rd(0, 5'd12);
                    expect_at("midrst_busy", K_BUSY, c, 0);
                    expect_at("midrst_perf", K_PERF, c, 32'(PERF_OK));
                    expect_at("midrst_ready", K_READY, c, 1);
                end
                7: begin rd(0, 5'd12); expect_at("postrst_ready", K_READY, c, 1); end
                default: ;
            endcase
            @(negedge clock);
            for (int i = 0; i < sbq.size(); ) begin
                if (sbq[i].due <= c) begin
                    got = observe(sbq[i].kind); n_tests++;
                    if (got !== sbq[i].val) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h", sbq[i].tag, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end else i++;
            end
            if (c == 6) reset_n = 1'b1;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        idle_inputs();
        @(posedge clock); #1;
        test_reset();
        test_fixed_bypass();
        test_fixed_stall();
        test_load();
        test_flush();
        test_resource();
        test_back_to_back();
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
